// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// big-endian byte-lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    localparam logic [1:0] LANE_MSB  = 2'd0;
    localparam logic [1:0] LANE_MID1 = 2'd1;
    localparam logic [1:0] LANE_MID0 = 2'd2;
    localparam logic [1:0] LANE_LSB  = 2'd3;

    // Bit position of the low bit of the addressed byte lane within a word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        logic [1:0] rev;
        rev = 2'(LANE_LSB - lane);
        return {rev, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit synchronous RAM with registered read and write enable.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // NOTE: neither the storage nor its read register is reset; contents must
    // survive reset and a resettable array would not map onto a RAM macro.
    // The read register only changes on a read, so it holds through writes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Request/response front end for the data memory: one outstanding access,
// word and big-endian byte loads/stores, byte stores done as read-modify-write.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = DEPTH_LOG2 + 2;

    state_t          state_q, state_d;
    logic            we_q, byte_q, signed_q, err_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic            accept, req_bad;
    logic            ram_en, ram_we;
    logic [31:0]     ram_wdata, ram_rdata;
    logic [4:0]      sh;
    logic [7:0]      lane_byte;
    logic [31:0]     load_val, merged;

    assign accept  = (state_q == IDLE) && req_valid;
    assign req_bad = (!req_byte && (req_addr[1:0] != 2'b00))
                   || ((req_addr >> AW) != 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                byte_q   <= req_byte;
                signed_q <= req_signed;
                err_q    <= req_bad;
                addr_q   <= req_addr[AW-1:0];
                wdata_q  <= req_wdata;
            end
        end
    end

    assign sh        = lane_lsb(addr_q[1:0]);
    assign lane_byte = 8'(ram_rdata >> sh);
    assign merged    = (ram_rdata & ~(32'h0000_00FF << sh))
                     | ({24'd0, wdata_q[7:0]} << sh);
    assign load_val  = !byte_q   ? ram_rdata
                     : signed_q  ? {{24{lane_byte[7]}}, lane_byte}
                     :             {24'd0, lane_byte};

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                ram_en = 1'b1;
                if (we_q && !byte_q) begin
                    ram_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = we_q ? MERGE : RESP;
                end
            end
            MERGE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response fields are forced to zero outside RESP and for stores/errors.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_val : 32'd0;

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[AW-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
